// File: rtl/fpu_div_sqrt.sv
// ---------------------------------------------------------------------------
// fpu_div_sqrt
//
// Single-precision (binary32) divide / square-root unit. One operation runs at
// a time. A start in IDLE or DONE latches the operands, 27 CALC cycles each
// produce one quotient/root bit, and one ROUND cycle applies round-to-nearest-
// even and writes the registered result.
//
// Ports:
//   clk        clock, rising-edge active
//   rst        synchronous reset, active low
//   start      request; accepted only in IDLE/DONE
//   inpA       dividend (divide) or radicand (sqrt)
//   inpB       divisor (ignored for sqrt)
//   operation  bit0: 1 = sqrt(A), 0 = A/B; bit1 reserved
//   res        result, held until the next accepted start
//   ready      high while res holds a completed result
// ---------------------------------------------------------------------------
module fpu_div_sqrt #(
  parameter int REG_SIZE = 32,
  parameter int OP_BITS  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [REG_SIZE-1:0] inpA,
  input  logic [REG_SIZE-1:0] inpB,
  input  logic [OP_BITS-1:0]  operation,
  output logic [REG_SIZE-1:0] res,
  output logic                ready
);

  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [4:0]  LAST_ITER = 5'd26;

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

  // Reserved opcode bits have no function.
  logic unused_op_bits;
  assign unused_op_bits = ^operation[OP_BITS-1:1];

  // -------------------------------------------------------------------------
  // Operand unpacking (denormals are treated as zero, sign kept)
  // -------------------------------------------------------------------------
  logic       a_sign, b_sign;
  logic [7:0] a_exp, b_exp;
  logic [22:0] a_frac, b_frac;
  logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [23:0] a_mant, b_mant;
  logic       inp_sqrt;

  assign a_sign = inpA[31];
  assign a_exp  = inpA[30:23];
  assign a_frac = inpA[22:0];
  assign b_sign = inpB[31];
  assign b_exp  = inpB[30:23];
  assign b_frac = inpB[22:0];

  assign a_zero = (a_exp == 8'd0);
  assign b_zero = (b_exp == 8'd0);
  assign a_inf  = (a_exp == 8'hFF) && (a_frac == 23'd0);
  assign b_inf  = (b_exp == 8'hFF) && (b_frac == 23'd0);
  assign a_nan  = (a_exp == 8'hFF) && (a_frac != 23'd0);
  assign b_nan  = (b_exp == 8'hFF) && (b_frac != 23'd0);
  assign a_mant = {1'b1, a_frac};
  assign b_mant = {1'b1, b_frac};
  assign inp_sqrt = operation[0];

  // -------------------------------------------------------------------------
  // Special-case detection, evaluated at accept and carried through the
  // pipeline so specials see the same latency as normal operands.
  // -------------------------------------------------------------------------
  logic        spec_hit;
  logic [31:0] spec_val;
  logic        q_sign;

  assign q_sign = a_sign ^ b_sign;

  always_comb begin
    spec_hit = 1'b1;
    spec_val = QNAN;
    if (inp_sqrt) begin
      if (a_nan)       spec_val = QNAN;
      else if (a_zero) spec_val = {a_sign, 31'd0};
      else if (a_sign) spec_val = QNAN;            // negative nonzero, incl. -inf
      else if (a_inf)  spec_val = {1'b0, 8'hFF, 23'd0};
      else             spec_hit = 1'b0;
    end else begin
      if (a_nan || b_nan)                          spec_val = QNAN;
      else if ((a_zero && b_zero) || (a_inf && b_inf)) spec_val = QNAN;
      else if (b_zero)                             spec_val = {q_sign, 8'hFF, 23'd0};
      else if (a_inf)                              spec_val = {q_sign, 8'hFF, 23'd0};
      else if (a_zero || b_inf)                    spec_val = {q_sign, 31'd0};
      else                                         spec_hit = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Initial exponent and radicand
  // -------------------------------------------------------------------------
  logic signed [9:0] div_exp_init;
  logic signed [9:0] sq_exp_unb, sq_exp_even, sq_exp_init;
  logic              sq_odd;
  logic [53:0]       sq_rad_init;

  assign div_exp_init = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + 10'sd127;

  // Biased exponent even <=> unbiased exponent odd.
  assign sq_odd      = ~a_exp[0];
  assign sq_exp_unb  = $signed({2'b00, a_exp}) - 10'sd127;
  assign sq_exp_even = sq_odd ? (sq_exp_unb - 10'sd1) : sq_exp_unb;
  assign sq_exp_init = (sq_exp_even >>> 1) + 10'sd127;

  // The mantissa (value in [1,4) after the odd-exponent shift) is scaled so
  // that its 27-bit integer square root carries the binary point after bit 26.
  assign sq_rad_init = {(sq_odd ? {a_mant, 1'b0} : {1'b0, a_mant}), 29'd0};

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  state_t            state_reg;
  logic [4:0]        count_reg;
  logic              sqrt_reg;
  logic              sign_reg;
  logic              special_reg;
  logic [31:0]       special_val_reg;
  logic signed [9:0] exp_reg;
  logic [23:0]       divisor_reg;
  logic [29:0]       rem_reg;    // partial remainder (shared by both ops)
  logic [26:0]       q_reg;      // quotient or root bits, MSB first
  logic [53:0]       rad_reg;    // radicand bit pairs not yet consumed

  // -------------------------------------------------------------------------
  // One restoring-division step
  // -------------------------------------------------------------------------
  logic [29:0] div_sub;
  logic        div_ge;
  logic [29:0] div_rem_next;

  assign div_sub      = rem_reg - {6'd0, divisor_reg};
  assign div_ge       = (rem_reg >= {6'd0, divisor_reg});
  assign div_rem_next = div_ge ? {div_sub[28:0], 1'b0} : {rem_reg[28:0], 1'b0};

  // -------------------------------------------------------------------------
  // One digit-by-digit square-root step
  // -------------------------------------------------------------------------
  logic [29:0] sq_rem_sh;
  logic [29:0] sq_trial;
  logic        sq_ge;
  logic [29:0] sq_rem_next;

  // Remainder never exceeds 2*root < 2^28, so its top two bits are free.
  assign sq_rem_sh   = {rem_reg[27:0], rad_reg[53:52]};
  assign sq_trial    = {1'b0, q_reg, 2'b01};
  assign sq_ge       = (sq_rem_sh >= sq_trial);
  assign sq_rem_next = sq_ge ? (sq_rem_sh - sq_trial) : sq_rem_sh;

  // -------------------------------------------------------------------------
  // Normalise, round (RNE) and pack
  // -------------------------------------------------------------------------
  logic              norm_shift;
  logic [23:0]       rnd_mant;
  logic              rnd_guard, rnd_sticky, round_up;
  logic [24:0]       mant_rnd;
  logic signed [9:0] exp_norm, exp_rnd;
  logic [22:0]       frac_out;
  logic [31:0]       round_result;

  // A divide quotient below 1.0 needs one left shift; a root never does.
  assign norm_shift = ~sqrt_reg & ~q_reg[26];

  always_comb begin
    if (norm_shift) begin
      rnd_mant   = q_reg[25:2];
      rnd_guard  = q_reg[1];
      rnd_sticky = q_reg[0] | (rem_reg != 30'd0);
      exp_norm   = exp_reg - 10'sd1;
    end else begin
      rnd_mant   = q_reg[26:3];
      rnd_guard  = q_reg[2];
      rnd_sticky = (|q_reg[1:0]) | (rem_reg != 30'd0);
      exp_norm   = exp_reg;
    end
  end

  assign round_up = rnd_guard & (rnd_sticky | rnd_mant[0]);
  assign mant_rnd = {1'b0, rnd_mant} + {24'd0, round_up};
  // A carry out of the mantissa leaves 1.000..0, so the fraction is zero.
  assign exp_rnd  = mant_rnd[24] ? (exp_norm + 10'sd1) : exp_norm;
  assign frac_out = mant_rnd[24] ? 23'd0 : mant_rnd[22:0];

  always_comb begin
    if (special_reg)               round_result = special_val_reg;
    else if (exp_rnd >= 10'sd255)  round_result = {sign_reg, 8'hFF, 23'd0};
    else if (exp_rnd <= 10'sd0)    round_result = {sign_reg, 31'd0};
    else                           round_result = {sign_reg, exp_rnd[7:0], frac_out};
  end

  // -------------------------------------------------------------------------
  // Control FSM and state updates
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= IDLE;
      count_reg       <= 5'd0;
      sqrt_reg        <= 1'b0;
      sign_reg        <= 1'b0;
      special_reg     <= 1'b0;
      special_val_reg <= 32'd0;
      exp_reg         <= 10'sd0;
      divisor_reg     <= 24'd0;
      rem_reg         <= 30'd0;
      q_reg           <= 27'd0;
      rad_reg         <= 54'd0;
      res             <= '0;
      ready           <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg       <= CALC;
            count_reg       <= 5'd0;
            ready           <= 1'b0;
            sqrt_reg        <= inp_sqrt;
            special_reg     <= spec_hit;
            special_val_reg <= spec_val;
            q_reg           <= 27'd0;
            divisor_reg     <= b_mant;
            rad_reg         <= sq_rad_init;
            if (inp_sqrt) begin
              sign_reg <= 1'b0;
              exp_reg  <= sq_exp_init;
              rem_reg  <= 30'd0;
            end else begin
              sign_reg <= q_sign;
              exp_reg  <= div_exp_init;
              rem_reg  <= {6'd0, a_mant};
            end
          end
        end

        CALC: begin
          if (sqrt_reg) begin
            rem_reg <= sq_rem_next;
            q_reg   <= {q_reg[25:0], sq_ge};
            rad_reg <= {rad_reg[51:0], 2'b00};
          end else begin
            rem_reg <= div_rem_next;
            q_reg   <= {q_reg[25:0], div_ge};
          end
          count_reg <= count_reg + 5'd1;
          if (count_reg == LAST_ITER) begin
            state_reg <= ROUND;
          end
        end

        ROUND: begin
          res       <= REG_SIZE'(round_result);
          ready     <= 1'b1;
          state_reg <= DONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_div_sqrt.sv
// ---------------------------------------------------------------------------
// tb_fpu_div_sqrt
//
// Scoreboard bench for fpu_div_sqrt. The stimulus process pushes the expected
// result and the accept cycle of every operation into queues; a monitor pops
// and compares on each rising edge of ready (result and 28-cycle latency).
// The reference model works on real numbers: operands are converted exactly
// to double, divided or square-rooted in double, then rounded once more to
// binary32 with round-to-nearest-even and the block's flush rules.
// ---------------------------------------------------------------------------
module tb_fpu_div_sqrt;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] inpA = '0;
  logic [31:0] inpB = '0;
  logic [1:0]  operation = '0;
  logic [31:0] res;
  logic        ready;

  fpu_div_sqrt #(.REG_SIZE(32), .OP_BITS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .inpA(inpA), .inpB(inpB),
    .operation(operation), .res(res), .ready(ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int n_issued = 0;
  int n_rise = 0;
  logic [31:0] last_exp = '0;

  logic [31:0] exp_q[$];
  int          acc_q[$];
  string       name_q[$];
  logic        ready_prev = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", nm, act, req);
    end else begin
      $display("ok   %s: %08h", nm, act);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    d = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    logic [24:0] m;
    logic        g, s;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    m = {2'b01, d[51:29]};
    g = d[28];
    s = |d[27:0];
    if (g && (s || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e++;
    end
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    if (e <= 0)   return {d[63], 31'd0};
    return {d[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic sq);
    logic az, bz, ai, bi, an, bn, s;
    az = (a[30:23] == 8'd0);
    bz = (b[30:23] == 8'd0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    s  = a[31] ^ b[31];
    if (sq) begin
      if (an) return QNAN;
      if (az) return {a[31], 31'd0};
      if (a[31]) return QNAN;
      if (ai) return 32'h7F80_0000;
      return r2f($sqrt(f2r(a)));
    end
    if (an || bn) return QNAN;
    if ((az && bz) || (ai && bi)) return QNAN;
    if (bz || ai) return {s, 8'hFF, 23'd0};
    if (az || bi) return {s, 31'd0};
    return r2f(f2r(a) / f2r(b));
  endfunction

  function automatic logic [31:0] rand_normal(input logic neg_ok);
    logic [31:0] x;
    x = $urandom;
    x[30:23] = 8'($urandom_range(1, 254));
    if (!neg_ok) x[31] = ($urandom_range(0, 7) == 0);
    return x;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (ready && !ready_prev) begin
      n_rise++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_ready: got ready rise with res=%08h, expected no result", res);
      end else begin
        logic [31:0] e;
        int          a;
        string       nm;
        e  = exp_q.pop_front();
        a  = acc_q.pop_front();
        nm = name_q.pop_front();
        check(nm, res, e);
        check({nm, "_latency"}, 32'(cyc - a), 32'd28);
      end
    end
    ready_prev <= ready;
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready(input string nm);
    int k;
    k = 0;
    while (!ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: ready=0 after 40 cycles, expected 1", nm);
    end
  endtask

  // Called at a negedge; hold = number of edges start stays high.
  task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input logic [31:0] expv, input int hold);
    inpA = a;
    inpB = b;
    operation = op;
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(expv);
    acc_q.push_back(cyc);
    name_q.push_back(nm);
    n_issued++;
    last_exp = expv;
    check({nm, "_ready_drop"}, {31'd0, ready}, 32'd0);
    for (int h = 1; h < hold; h++) begin
      @(negedge clk);
      inpA = $urandom;
      inpB = $urandom;
      operation = 2'($urandom);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    start = 1'b0;
    inpA = $urandom;
    inpB = $urandom;
    operation = 2'($urandom);
    wait_ready(nm);
    repeat ($urandom_range(0, 1)) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_res", res, 32'd0);
    check("reset_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed divide cases
    do_op("div_6_over_2",  32'h40C00000, 32'h40000000, 2'b00, 32'h40400000, 1);
    do_op("div_1_over_3",  32'h3F800000, 32'h40400000, 2'b10, 32'h3EAAAAAB, 1);
    do_op("div_1_over_0",  32'h3F800000, 32'h00000000, 2'b00, 32'h7F800000, 1);
    do_op("div_1_over_n0", 32'h3F800000, 32'h80000000, 2'b00, 32'hFF800000, 1);
    do_op("div_0_over_0",  32'h00000000, 32'h00000000, 2'b00, QNAN, 1);
    do_op("div_inf_inf",   32'h7F800000, 32'hFF800000, 2'b00, QNAN, 1);
    do_op("div_nan",       32'h7F800001, 32'h3F800000, 2'b00, QNAN, 1);
    do_op("div_inf_over_0",32'h7F800000, 32'h00000000, 2'b00, 32'h7F800000, 1);
    do_op("div_ninf_2",    32'hFF800000, 32'h40000000, 2'b00, 32'hFF800000, 1);
    do_op("div_n0_over_2", 32'h80000000, 32'h40000000, 2'b00, 32'h80000000, 1);
    do_op("div_1_over_ninf",32'h3F800000,32'hFF800000, 2'b00, 32'h80000000, 1);
    do_op("div_denorm",    32'h80400000, 32'h40000000, 2'b00, 32'h80000000, 1);
    do_op("div_overflow",  32'h7F000000, 32'h00800000, 2'b00, 32'h7F800000, 1);
    do_op("div_underflow", 32'h00800000, 32'h7F000000, 2'b00, 32'h00000000, 1);

    // Directed sqrt cases (inpB is random and must be ignored)
    do_op("sqrt_4",     32'h40800000, $urandom, 2'b01, 32'h40000000, 1);
    do_op("sqrt_neg1",  32'hBF800000, $urandom, 2'b11, QNAN, 1);
    do_op("sqrt_n0",    32'h80000000, $urandom, 2'b01, 32'h80000000, 1);
    do_op("sqrt_ndenorm",32'h80000001,$urandom, 2'b01, 32'h80000000, 1);
    do_op("sqrt_inf",   32'h7F800000, $urandom, 2'b01, 32'h7F800000, 1);
    do_op("sqrt_ninf",  32'hFF800000, $urandom, 2'b01, QNAN, 1);
    do_op("sqrt_nan",   32'h7FA00000, $urandom, 2'b01, QNAN, 1);
    do_op("sqrt_2",     32'h40000000, $urandom, 2'b01, 32'h3FB504F3, 1);

    // Start held for 3 edges while inputs change: only one operation runs
    do_op("held_start", 32'h3F800000, 32'h40400000, 2'b00, 32'h3EAAAAAB, 3);

    // Reset during CALC aborts the operation
    @(negedge clk);
    inpA = 32'h40C00000;
    inpB = 32'h40000000;
    operation = 2'b00;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_res", res, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    do_op("after_abort", 32'h40C00000, 32'h40000000, 2'b00, 32'h40400000, 1);

    // Random back-to-back normal operands
    for (int i = 0; i < 512; i++) begin
      logic [31:0] a, b;
      logic        sq;
      sq = 1'($urandom);
      a  = rand_normal(!sq);
      b  = rand_normal(1'b1);
      do_op($sformatf("rand_%0d_%s", i, sq ? "sqrt" : "div"), a, b,
            {1'($urandom), sq}, ref_model(a, b, sq), 1);
    end

    // Result and ready held in DONE
    repeat (6) @(negedge clk);
    check("hold_res", res, last_exp);
    check("hold_ready", {31'd0, ready}, 32'd1);
    check("ready_rises", 32'(n_rise), 32'(n_issued));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
